// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two DMem requesters, the arbiter and the DMem itself.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives requests and returns memory read data.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              owner;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_we, busy, owner
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_we, busy, owner
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the single-port DMem between the CPU load/store
// path (port 0) and the loader/DMA path (port 1). Each transaction takes one
// IDLE sample cycle, one ACCESS cycle on the memory and one DONE cycle that
// pulses the owner's ack. The arbiter is the sole driver of the DMem bus.
module dmem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    dmem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_owner;
    logic              r_rrPtr;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              w_anyReq;
    logic              w_winner;
    logic              w_start;
    logic              w_ack0;
    logic              w_ack1;
    logic              w_busy;

    assign w_anyReq = bus.req0 | bus.req1;
    assign w_start  = (r_state == ST_IDLE) && w_anyReq;

    // Winner selection: a lone requester wins outright, a tie goes to the round-robin pointer
    always_comb begin
        w_winner = r_rrPtr;
        if (bus.req0 && !bus.req1) begin
            w_winner = 1'b0;
        end else if (!bus.req0 && bus.req1) begin
            w_winner = 1'b1;
        end
    end

    // Next-state and handshake output decode for the IDLE -> ACCESS -> DONE cycle
    always_comb begin
        w_nextState = r_state;
        w_ack0      = 1'b0;
        w_ack1      = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_anyReq) begin
                    w_nextState = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_busy      = 1'b1;
                w_nextState = ST_DONE;
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_ack0      = ~r_owner;
                w_ack1      = r_owner;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Grant bookkeeping: owner latched at the IDLE sample, pointer moves past the owner on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_rrPtr <= 1'b0;
        end else begin
            if (w_start) begin
                r_owner <= w_winner;
            end
            if (r_state == ST_DONE) begin
                r_rrPtr <= ~r_owner;
            end
        end
    end

    // Memory bus: the winner's request is captured on entry to ACCESS so a requester that
    // drops req mid-transaction cannot disturb it; the write strobe lives for ACCESS only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memWe    <= 1'b0;
        end else if (w_start) begin
            r_memAddr  <= w_winner ? bus.addr1  : bus.addr0;
            r_memWdata <= w_winner ? bus.wdata1 : bus.wdata0;
            r_memWe    <= w_winner ? bus.we1    : bus.we0;
        end else begin
            r_memWe    <= 1'b0;
        end
    end

    // Read return: capture DMem data into the owner's holding register at the close of a read ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if ((r_state == ST_ACCESS) && !r_memWe) begin
            if (r_owner) begin
                r_rdata1 <= bus.mem_rdata;
            end else begin
                r_rdata0 <= bus.mem_rdata;
            end
        end
    end

    // Reset gates the strobe so a write caught in ACCESS never reaches DMem on the reset edge
    assign bus.mem_we    = r_memWe & ~rst;
    assign bus.mem_addr  = r_memAddr;
    assign bus.mem_wdata = r_memWdata;
    assign bus.ack0      = w_ack0;
    assign bus.ack1      = w_ack1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
    assign bus.busy      = w_busy;
    assign bus.owner     = r_owner;

endmodule
